// File: rtl/clk_div_ratio_ctrl.sv
// Config stage for the programmable clock divider: takes ratio/enable requests and
// applies them only on a divided-clock period boundary, then holds busy for a settle window.
module clk_div_ratio_ctrl #(
    parameter int WIDTH      = 8,
    parameter int RST_RATIO  = 1,
    parameter int SETTLE_CYC = 2
) (
    input  logic             I_ref_clk,
    input  logic             I_rst,
    input  logic             I_cfg_valid,
    input  logic [WIDTH-1:0] I_cfg_ratio,
    input  logic             I_cfg_en,
    output logic [WIDTH-1:0] O_div_ratio,
    output logic             O_clk_en,
    output logic             O_busy,
    output logic             O_cfg_ack,
    output logic             O_cfg_ovr
);

    localparam int SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [1:0] {IDLE, PEND, SETTLE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] ratio_q, pend_ratio_q, cnt_q, last_d;
    logic             en_q, pend_en_q, busy_q, ack_q, ovr_q;
    logic [SCW-1:0]   scnt_q;
    logic             active_d, boundary_d;

    // last_d is forced to 0 for ratio<=1 so ratio-1 never wraps.
    always_comb begin
        active_d   = en_q && (ratio_q > WIDTH'(1));
        last_d     = (ratio_q > WIDTH'(1)) ? ratio_q - WIDTH'(1) : '0;
        boundary_d = active_d && (cnt_q == last_d);
    end

    always_ff @(posedge I_ref_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q      <= IDLE;
            ratio_q      <= WIDTH'(RST_RATIO);
            en_q         <= 1'b0;
            busy_q       <= 1'b0;
            ack_q        <= 1'b0;
            ovr_q        <= 1'b0;
            pend_ratio_q <= '0;
            pend_en_q    <= 1'b0;
            cnt_q        <= '0;
            scnt_q       <= '0;
        end else begin
            ack_q <= 1'b0;
            ovr_q <= 1'b0;

            if (!active_d || boundary_d)
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + WIDTH'(1);

            case (state_q)
                IDLE: begin
                    if (I_cfg_valid) begin
                        pend_ratio_q <= I_cfg_ratio;
                        pend_en_q    <= I_cfg_en;
                        busy_q       <= 1'b1;
                        state_q      <= PEND;
                    end
                end
                PEND: begin
                    if (I_cfg_valid)
                        ovr_q <= 1'b1;
                    // In bypass there is no period to protect, so load at once.
                    if (!active_d || boundary_d) begin
                        ratio_q <= pend_ratio_q;
                        en_q    <= pend_en_q;
                        cnt_q   <= '0;
                        ack_q   <= 1'b1;
                        scnt_q  <= '0;
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (I_cfg_valid)
                        ovr_q <= 1'b1;
                    if (scnt_q == SCW'(SETTLE_CYC - 1)) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        scnt_q <= scnt_q + SCW'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign O_div_ratio = ratio_q;
    assign O_clk_en    = en_q;
    assign O_busy      = busy_q;
    assign O_cfg_ack   = ack_q;
    assign O_cfg_ovr   = ovr_q;

endmodule

// File: tb/tb_clk_div_ratio_ctrl.sv
// Cycle-by-cycle vector bench for clk_div_ratio_ctrl; expected outputs are hand-derived
// per cycle and routed through a scoreboard queue.
module tb_clk_div_ratio_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid;
    logic [W-1:0] ratio;
    logic         en;
    logic [W-1:0] div_ratio;
    logic         clk_en, busy, ack, ovr;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic         v;
        logic [W-1:0] r;
        logic         e;
        logic [W-1:0] xr;
        logic         xe, xb, xa, xo;
    } vec_t;

    typedef struct {
        int           idx;
        logic [W-1:0] xr;
        logic         xe, xb, xa, xo;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];

    clk_div_ratio_ctrl #(.WIDTH(W), .RST_RATIO(1), .SETTLE_CYC(2)) dut (
        .I_ref_clk  (clk),
        .I_rst      (rst),
        .I_cfg_valid(valid),
        .I_cfg_ratio(ratio),
        .I_cfg_en   (en),
        .O_div_ratio(div_ratio),
        .O_clk_en   (clk_en),
        .O_busy     (busy),
        .O_cfg_ack  (ack),
        .O_cfg_ovr  (ovr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    task automatic add(input logic v, input int r, input logic e,
                       input int xr, input logic xe, input logic xb,
                       input logic xa, input logic xo);
        vec_t t;
        t.v = v; t.r = W'(r); t.e = e;
        t.xr = W'(xr); t.xe = xe; t.xb = xb; t.xa = xa; t.xo = xo;
        vecs.push_back(t);
    endtask

    task automatic cmp(input string name, input int idx, input logic [W-1:0] xr,
                       input logic xe, input logic xb, input logic xa, input logic xo);
        checks++;
        if (div_ratio !== xr || clk_en !== xe || busy !== xb || ack !== xa || ovr !== xo) begin
            errors++;
            $display("FAIL %s[%0d]: got ratio=%0d en=%b busy=%b ack=%b ovr=%b, want ratio=%0d en=%b busy=%b ack=%b ovr=%b",
                     name, idx, div_ratio, clk_en, busy, ack, ovr, xr, xe, xb, xa, xo);
        end
    endtask

    task automatic sb_check(input string name);
        exp_t x;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got ratio=%0d, want a queued entry", name, div_ratio);
        end else begin
            x = sbq.pop_front();
            cmp(name, x.idx, x.xr, x.xe, x.xb, x.xa, x.xo);
        end
    endtask

    initial begin
        exp_t x;
        rst = 1'b1; valid = 1'b0; ratio = '0; en = 1'b0;

        // fields: valid, ratio, en  ->  ratio, en, busy, ack, ovr after the edge
        // bypass apply: one-cycle load, busy for 1+SETTLE_CYC cycles
        add(1,4,1, 1,0,1,0,0); add(0,0,0, 4,1,1,1,0); add(0,0,0, 4,1,1,0,0);
        add(0,0,0, 4,1,0,0,0); add(0,0,0, 4,1,0,0,0); add(0,0,0, 4,1,0,0,0);
        add(0,0,0, 4,1,0,0,0);
        // ratio 4 -> 6 requested at cnt=1, loads on the cnt==3 edge
        add(1,6,1, 4,1,1,0,0); add(0,0,0, 4,1,1,0,0); add(0,0,0, 6,1,1,1,0);
        add(0,0,0, 6,1,1,0,0); add(0,0,0, 6,1,0,0,0);
        // ratio 6 -> 5, then 5 -> 2 loads on cnt==4
        add(1,5,1, 6,1,1,0,0); add(0,0,0, 6,1,1,0,0); add(0,0,0, 6,1,1,0,0);
        add(0,0,0, 5,1,1,1,0); add(0,0,0, 5,1,1,0,0); add(0,0,0, 5,1,0,0,0);
        add(1,2,1, 5,1,1,0,0); add(0,0,0, 5,1,1,0,0); add(0,0,0, 2,1,1,1,0);
        add(0,0,0, 2,1,1,0,0); add(0,0,0, 2,1,0,0,0);
        // identical request: boundary one edge after accept, ack still issued
        add(1,2,1, 2,1,1,0,0); add(0,0,0, 2,1,1,1,0); add(0,0,0, 2,1,1,0,0);
        add(0,0,0, 2,1,0,0,0); add(0,0,0, 2,1,0,0,0);
        // overrun in PEND and in SETTLE (incl. the SETTLE->IDLE edge)
        add(1,3,1, 2,1,1,0,0); add(1,7,0, 2,1,1,0,1); add(0,0,0, 3,1,1,1,0);
        add(1,9,1, 3,1,1,0,1); add(1,9,1, 3,1,0,0,1); add(0,0,0, 3,1,0,0,0);
        // disable waits for cnt==2
        add(1,3,0, 3,1,1,0,0); add(0,0,0, 3,1,1,0,0); add(0,0,0, 3,0,1,1,0);
        add(0,0,0, 3,0,1,0,0); add(0,0,0, 3,0,0,0,0);
        // disabled -> bypass path again
        add(1,5,1, 3,0,1,0,0); add(0,0,0, 5,1,1,1,0); add(0,0,0, 5,1,1,0,0);
        add(0,0,0, 5,1,0,0,0);
        // ratio 0 waits for boundary; afterwards it behaves as bypass
        add(1,0,1, 5,1,1,0,0); add(0,0,0, 5,1,1,0,0); add(0,0,0, 0,1,1,1,0);
        add(0,0,0, 0,1,1,0,0); add(0,0,0, 0,1,0,0,0);
        add(1,1,1, 0,1,1,0,0); add(0,0,0, 1,1,1,1,0); add(0,0,0, 1,1,1,0,0);
        add(0,0,0, 1,1,0,0,0);
        // get to PEND on a running ratio 4 for the reset test
        add(1,4,1, 1,1,1,0,0); add(0,0,0, 4,1,1,1,0); add(0,0,0, 4,1,1,0,0);
        add(0,0,0, 4,1,0,0,0); add(1,8,1, 4,1,1,0,0);

        repeat (2) @(posedge clk);
        #1;
        cmp("reset", 0, W'(1), 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            valid = vecs[i].v; ratio = vecs[i].r; en = vecs[i].e;
            x.idx = i; x.xr = vecs[i].xr; x.xe = vecs[i].xe;
            x.xb = vecs[i].xb; x.xa = vecs[i].xa; x.xo = vecs[i].xo;
            sbq.push_back(x);
            @(posedge clk);
            #1;
            sb_check("vec");
        end

        // async reset mid-PEND: immediate effect, request discarded, no later ack
        @(negedge clk);
        valid = 1'b0;
        rst = 1'b1;
        #1;
        cmp("rst_async", 0, W'(1), 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            x.idx = i; x.xr = W'(1); x.xe = 1'b0; x.xb = 1'b0; x.xa = 1'b0; x.xo = 1'b0;
            sbq.push_back(x);
            @(posedge clk);
            #1;
            sb_check("post_rst");
        end

        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_drain: %0d entries left, want 0", sbq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
